// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore-style control FSM for the multicycle MIPS datapath. Sequences each
// instruction through FETCH / DECODE / execute / write-back states and drives
// every datapath control strobe.
//
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   Op          - instruction[31:26] from the IR
//   Funct       - instruction[5:0] from the IR
//   Zero        - ALU result-equals-zero flag
//   PCEn        - PC load enable
//   IorD        - memory address select (0 = PC, 1 = ALUOut)
//   MemWrite    - data memory write strobe
//   IRWrite     - instruction register load
//   RegDst      - write register select (0 = rt, 1 = rd)
//   MemtoReg    - write-back data select (0 = ALUOut, 1 = Data)
//   RegWrite    - register file write enable
//   ALUSrcA     - ALU A select (0 = PC, 1 = reg A)
//   ALUSrcB     - ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   ALUControl  - ALU operation
//   PCSrc       - next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   state_o     - current state, debug visibility
//   instr_done  - high in the final state of every instruction
//
// Outputs are combinational from the state (plus Op/Funct/Zero where an
// output depends on them) and are all forced low while reset is asserted, so
// the FETCH strobes cannot write the PC or IR during reset.
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic [3:0] state_o,
    output logic       instr_done
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEX   = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t     state;
    logic       op_legal;
    logic       funct_legal;
    logic [3:0] funct_alu;

    // Opcode legality: anything outside the supported set is dropped in DECODE.
    always_comb begin
        op_legal = 1'b0;
        case (Op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // R-type funct decode; illegal funct leaves ALU at ADD and aborts the op.
    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (Funct)
            FN_ADD:  funct_alu = ALU_ADD;
            FN_SUB:  funct_alu = ALU_SUB;
            FN_AND:  funct_alu = ALU_AND;
            FN_OR:   funct_alu = ALU_OR;
            FN_SLT:  funct_alu = ALU_SLT;
            FN_NOR:  funct_alu = ALU_NOR;
            default: funct_legal = 1'b0;
        endcase
    end

    // State register. Unused encodings 12-15 fall into the default arm and
    // return to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= DECODE;
                DECODE: begin
                    case (Op)
                        OP_LW, OP_SW:   state <= MEMADR;
                        OP_RTYPE:       state <= EXECUTE;
                        OP_BEQ, OP_BNE: state <= BRANCH;
                        OP_ADDI:        state <= ADDIEX;
                        OP_J:           state <= JUMP;
                        default:        state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (Op == OP_SW) ? MEMWRITE : MEMREAD;
                MEMREAD: state <= MEMWB;
                EXECUTE: state <= funct_legal ? ALUWB : FETCH;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Output decode. Reset gating is applied last so it overrides every state.
    always_comb begin
        PCEn       = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        PCSrc      = 2'b00;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCEn    = 1'b1;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                instr_done = ~op_legal;
            end
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMREAD: IorD = 1'b1;
            MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                instr_done = ~funct_legal;
            end
            ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                // Zero is used directly in this cycle; bne takes the inverse.
                PCEn       = (Op == OP_BNE) ? ~Zero : Zero;
                instr_done = 1'b1;
            end
            ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JUMP: begin
                PCSrc      = 2'b10;
                PCEn       = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            PCEn       = 1'b0;
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUControl = 4'b0000;
            PCSrc      = 2'b00;
            instr_done = 1'b0;
        end
    end

    assign state_o = reset ? state : 4'd0;

endmodule
